// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - PS/2 keyboard receiver with E0/F0 prefix folding and FWFT event FIFO
module ps2_event_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    line_f;
  logic [FW-1:0] fcnt [2];
  logic          clk_f_d;
  logic          fall;
  logic          data_f;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      line_f  <= 2'b11;
      clk_f_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1   <= {ps2_data, ps2_clk};
      sync2   <= sync1;
      clk_f_d <= line_f[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == line_f[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          line_f[i] <= sync2[i];
          fcnt[i]   <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clk_f_d & ~line_f[0];
  assign data_f = line_f[1];

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          stop_ok;
  logic          stop_bad;
  logic          abort;
  logic          byte_stb;
  logic [7:0]    byte_q;

  always_ff @(posedge clk_25mhz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_f) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // a fall always restarts the timeout window, so it wins over an expiry
  always_comb begin
    timeout  = !fall && (state_q != IDLE) && (to_cnt == TW'(TIMEOUT_CYC));
    stop_ok  = fall && (state_q == STOP) && data_f && (^{shift_q, par_q});
    stop_bad = fall && (state_q == STOP) && !(data_f && (^{shift_q, par_q}));
    abort    = timeout || stop_bad;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt    <= '0;
      byte_stb  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= stop_ok;
      frame_err <= abort;
      if (stop_ok) byte_q <= shift_q;
      if (state_q == IDLE || fall || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state_q)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shift_q <= {data_f, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_q <= data_f;
          default: ;
        endcase
      end
    end
  end

  logic       ext_q;
  logic       brk_q;
  logic       push;
  logic [9:0] wdata;

  assign push  = byte_stb && (byte_q != 8'hE0) && (byte_q != 8'hF0);
  assign wdata = {ext_q, brk_q, byte_q};

  always_ff @(posedge clk_25mhz) begin
    if (reset || abort) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_stb) begin
      if (byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_q;
  logic [CW-1:0] after_pop;
  logic [9:0]    head_q;
  logic          pop;
  logic          full;
  logic          wr;

  always_comb begin
    pop       = rd_en && (count_q != '0);
    full      = (count_q == CW'(FIFO_DEPTH));
    wr        = push && (!full || pop);
    rd_next   = rd_ptr + AW'(pop);
    after_pop = count_q - CW'(pop);
  end

  always_ff @(posedge clk_25mhz) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  // head is registered so it keeps the last popped entry while empty
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_next;
      count_q <= count_q + CW'(wr) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      if (after_pop != '0) head_q <= mem[rd_next];
      else if (wr)         head_q <= wdata;
    end
  end

  assign ev_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign ev_ext     = head_q[9];
  assign ev_break   = head_q[8];
  assign ev_code    = head_q[7:0];

endmodule

// File: tb/tb_ps2_event_fifo.sv
// tb/tb_ps2_event_fifo.sv - directed self-checking bench for ps2_event_fifo
module tb_ps2_event_fifo;

  localparam int H_SLOW = 500;
  localparam int H_FAST = 16;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       rd_en     = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int errors     = 0;
  int checks     = 0;
  int err_pulses = 0;
  int e0;

  ps2_event_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(16), .TIMEOUT_CYC(50000)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_break  (ev_break),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  always @(negedge clk_25mhz) if (frame_err) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  // mode 1: check ev_valid latency after the stop fall; mode 2: pop in the write cycle
  task automatic send_bits(input logic [7:0] b, input int nbits, input int h, input int mode,
                           input logic flip, input logic stop);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(h / 2);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        wait_cyc(11);
        chk("lat_pre", ev_valid, 0);
        wait_cyc(1);
        chk("lat_valid", ev_valid, 1);
        wait_cyc(h - 12);
      end else if (i == 10 && mode == 2) begin
        wait_cyc(11);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        wait_cyc(h - 12);
      end else begin
        wait_cyc(h);
      end
      ps2_clk = 1'b1;
      wait_cyc(h - h / 2);
    end
    ps2_data = 1'b1;
    wait_cyc(h);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 11, H_FAST, 0, 1'b0, 1'b1);
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, ev_valid, 1);
    chk(tag, {ev_ext, ev_break, ev_code}, exp);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    wait_cyc(4);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_head", {ev_ext, ev_break, ev_code}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b0;
    wait_cyc(5);

    send_bits(8'h1C, 11, H_SLOW, 1, 1'b0, 1'b1);
    chk("make_head", {ev_ext, ev_break, ev_code}, 10'h01C);
    chk("make_count", fifo_count, 1);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    chk("make_pop_valid", ev_valid, 0);
    chk("make_pop_count", fifo_count, 0);

    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_count", fifo_count, 1);
    pop_chk("ext_brk", 10'h375);
    send(8'h1C);
    pop_chk("flags_clr", 10'h01C);
    send(8'hF0);
    send(8'hE0);
    send(8'h6B);
    pop_chk("order_indep", 10'h36B);
    send(8'hAA);
    pop_chk("plain_aa", 10'h0AA);

    e0 = err_pulses;
    send_bits(8'h1C, 11, H_FAST, 0, 1'b1, 1'b1);
    chk("par_err", err_pulses, e0 + 1);
    chk("par_noev", fifo_count, 0);
    send_bits(8'h1C, 11, H_FAST, 0, 1'b0, 1'b0);
    chk("stop_err", err_pulses, e0 + 2);
    chk("stop_noev", fifo_count, 0);
    send(8'hF0);
    send_bits(8'h1C, 11, H_FAST, 0, 1'b1, 1'b1);
    send(8'h1C);
    chk("bad_clr_err", err_pulses, e0 + 3);
    pop_chk("bad_clr", 10'h01C);

    e0 = err_pulses;
    send_bits(8'h55, 4, H_FAST, 0, 1'b0, 1'b1);
    wait_cyc(49700);
    chk("to_early", err_pulses, e0);
    wait_cyc(500);
    chk("to_err", err_pulses, e0 + 1);
    send(8'h32);
    pop_chk("to_next", 10'h032);

    e0 = err_pulses;
    ps2_data = 1'b0;
    repeat (5) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(50);
    chk("glitch_noerr", err_pulses, e0);
    chk("glitch_noev", fifo_count, 0);
    send(8'h32);
    pop_chk("glitch_next", 10'h032);
    chk("glitch_noerr2", err_pulses, e0);

    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) pop_chk("ovf_order", 10'h010 + 10'(i));
    chk("ovf_17th_absent", ev_valid, 0);

    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    chk("rst2_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
    chk("fill_count", fifo_count, 16);
    send_bits(8'h50, 11, H_FAST, 2, 1'b0, 1'b1);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_ovf", overflow, 0);
    for (int i = 1; i <= 16; i++) pop_chk("fullpop_order", 10'h040 + 10'(i));
    chk("fullpop_empty", ev_valid, 0);

    send(8'hE0);
    send(8'h21);
    chk("pre_rst_head", {ev_ext, ev_break, ev_code}, 10'h221);
    send_bits(8'h5A, 5, H_FAST, 0, 1'b0, 1'b1);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    chk("midrst_valid", ev_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_head", {ev_ext, ev_break, ev_code}, 0);
    chk("midrst_ovf", overflow, 0);
    e0 = err_pulses;
    send(8'h4D);
    pop_chk("midrst_next", 10'h04D);
    chk("midrst_noerr", err_pulses, e0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_event_fifo.md
Name: ps2_event_fifo

Overview:
- Parametrised PS/2 keyboard receiver for the keyboard input path, upstream of scan-code-to-symbol translation.
- Glitch-filters `ps2_clk` and `ps2_data`, then decodes complete 11-bit frames with start, odd-parity and stop checking and a frame timeout.
- Folds the E0 (extended) and F0 (break) prefixes into one event per key action.
- Queues events in a first-word-fall-through FIFO, so no keystroke is lost while the consumer is busy.

Parameters:
- FILTER_LEN, 8: number of consecutive equal samples needed to change a filtered line; range 2..32.
- FIFO_DEPTH, 16: event FIFO entries; power of 2, range 2..256.
- TIMEOUT_CYC, 50000: clk_25mhz cycles without a filtered falling edge before a partial frame is aborted (2 ms at 25 MHz).

Ports:
- `clk_25mhz`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `rd_en`  in  1  pop the head event; honoured only when `ev_valid`=1.
- `ev_valid`  out  1  FIFO not empty.
- `ev_code`  out  8  head event scan code.
- `ev_ext`  out  1  head event was preceded by E0.
- `ev_break`  out  1  head event is a key release (preceded by F0).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse per rejected or aborted frame.

Behaviour:
- Reset: synchronous, active-high, with priority over all other logic, including mid-frame. Values after reset:
  - synchronisers and filtered lines = 1;
  - frame FSM in IDLE, bit counter and timeout counter = 0;
  - prefix flags cleared;
  - FIFO empty;
  - `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_break`=0, `fifo_count`=0, `overflow`=0, `frame_err`=0.
- Input conditioning:
  - Each raw line passes through a 2-flop synchroniser, then a filter.
  - The filter output changes only after FILTER_LEN consecutive identical synchronised samples.
  - `fall` is a one-cycle strobe when filtered `ps2_clk` goes 1->0. All frame sampling uses filtered data in the `fall` cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on `fall` with data=0, go to DATA with bit count 0. On `fall` with data=1, stay in IDLE and do not pulse `frame_err`.
  - DATA: on each `fall`, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, record the parity bit and go to STOP. The frame is good only if the eight data bits plus the parity bit contain an odd number of ones.
  - STOP: on `fall`, go to IDLE. If data=1 and parity is good, pulse `byte_stb` with the byte. Otherwise pulse `frame_err`, drop the byte and clear the prefix flags.
  - Timeout: the counter runs whenever the FSM is not in IDLE and clears on every `fall`. When it reaches TIMEOUT_CYC, pulse `frame_err`, return to IDLE and clear the prefix flags.
- Prefix decoder, acting on `byte_stb`:
  - 0xE0: set `ext` and emit nothing.
  - 0xF0: set `brk` and emit nothing.
  - Any other byte: emit {`ext`, `brk`, byte} in the next cycle, then clear both flags.
  - E0 and F0 are order-independent; E0 F0 xx and F0 E0 xx give the same event.
  - Non-prefix bytes such as 0xAA, 0xFA and 0xE1 are emitted as ordinary events.
- Latency: `ev_valid` rises exactly 2 cycles after the STOP `fall` cycle of the final byte when the FIFO was empty (`byte_stb` registered at +1, FIFO written at +1, visible at +2).
- FIFO:
  - Write port: 10-bit entries, one write per event.
  - Read: first-word-fall-through. The head entry is on `ev_code`/`ev_ext`/`ev_break` whenever `ev_valid`=1. `rd_en` pops it on the same edge; `rd_en` while empty is ignored.
  - Full with no pop: the event is dropped and `overflow` is set (sticky until reset); `fifo_count` stays FIFO_DEPTH.
  - Full with a concurrent pop: the write is accepted and the count is unchanged.
  - Empty with a concurrent push: `ev_valid` rises the next cycle; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty, the head outputs hold their last values; consumers must qualify them with `ev_valid`.

Test Plan:
- Make A: send frame 0x1C with correct parity (PS/2 half-period 500 cycles) -> `ev_valid` rises 2 cycles after the stop fall; head = {ext=0, break=0, code=0x1C}; `fifo_count`=1; `rd_en` for 1 cycle -> `ev_valid`=0, `fifo_count`=0.
- Extended release: send E0, F0, 0x75 -> exactly one event {ext=1, break=1, code=0x75}; then send 0x1C -> {0, 0, 0x1C}, confirming the flags were cleared.
- Errors: 0x1C with a flipped parity bit -> one `frame_err` pulse, no event. Stop bit 0 -> one `frame_err` pulse, no event. Send F0 then a bad frame then 0x1C -> {0, 0, 0x1C}.
- Timeout and glitches:
  - Start bit plus 3 data bits, then idle 50000 cycles -> `frame_err` pulse; the next good frame 0x32 decodes correctly.
  - 3-cycle low glitches on `ps2_clk` -> no bit is sampled.
- Overflow: with FIFO_DEPTH=16 and no reads, send 17 makes -> `fifo_count`=16, `overflow`=1. The first 16 codes pop in order; the 17th is absent.
- Full with simultaneous pop, then reset mid-frame:
  - With FIFO_DEPTH=16, fill to 16; hold `rd_en`=1 in the write cycle -> count stays 16 and `overflow` stays 0.
  - Assert `reset` after 4 data bits -> all outputs reset; the next full frame decodes correctly.
